// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and helpers for the pipeline-stage skid register.
// Holds the default entry layout, the bubble instruction and the counter saturation helper.
package pipe_pkg;

    localparam int unsigned ENTRY_INSTR_W = 32;
    localparam int unsigned ENTRY_PC_W    = 32;

    localparam logic [ENTRY_INSTR_W-1:0] NOP_WORD_DEF = '0;

    typedef struct packed {
        logic [ENTRY_INSTR_W-1:0] instr;
        logic [ENTRY_PC_W-1:0]    pcplus;
        logic                     irq;
        logic                     valid;
    } stage_entry_t;

    // Increment that sticks at the all-ones value of a counter `width` bits wide.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] limit;
        limit = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (value >= limit) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between two pipeline stages: upstream beat in, downstream beat out.
interface pipe_stage_skid_if
    import pipe_pkg::*;
#(
    parameter int unsigned INSTR_W = ENTRY_INSTR_W,
    parameter int unsigned PC_W    = ENTRY_PC_W
);

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [PC_W-1:0]    in_pcplus;
    logic               in_irq;

    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pcplus;
    logic               out_irq;

    // The stage itself.
    modport slave (
        input  in_valid, in_instr, in_pcplus, in_irq, out_ready,
        output in_ready, out_valid, out_instr, out_pcplus, out_irq
    );

    // The surrounding pipeline: fetch side drives beats, decode side drives out_ready.
    modport master (
        output in_valid, in_instr, in_pcplus, in_irq, out_ready,
        input  in_ready, out_valid, out_instr, out_pcplus, out_irq
    );

endinterface

// File: rtl/pipe_stage_skid_slot.sv
// One pipeline entry register {instr, pcplus, irq, valid}; used for both the main and skid slots.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned        INSTR_W  = ENTRY_INSTR_W,
    parameter int unsigned        PC_W     = ENTRY_PC_W,
    parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(NOP_WORD_DEF)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               clear,
    input  logic               bubble,
    input  logic [INSTR_W-1:0] d_instr,
    input  logic [PC_W-1:0]    d_pcplus,
    input  logic               d_irq,
    input  logic [PC_W-1:0]    bub_pcplus,
    output logic [INSTR_W-1:0] q_instr,
    output logic [PC_W-1:0]    q_pcplus,
    output logic               q_irq,
    output logic               q_valid
);

    // bubble: empty with a new pcplus; clear: empty keeping pcplus; load: take the beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_instr  <= NOP_WORD;
            q_pcplus <= '0;
            q_irq    <= 1'b0;
            q_valid  <= 1'b0;
        end else if (bubble) begin
            q_instr  <= NOP_WORD;
            q_pcplus <= bub_pcplus;
            q_irq    <= 1'b0;
            q_valid  <= 1'b0;
        end else if (clear) begin
            q_instr  <= NOP_WORD;
            q_irq    <= 1'b0;
            q_valid  <= 1'b0;
        end else if (load) begin
            q_instr  <= d_instr;
            q_pcplus <= d_pcplus;
            q_irq    <= d_irq;
            q_valid  <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// IF/ID-style pipeline stage: main + skid entry with valid/ready, flush-to-bubble,
// sticky interrupt carry across flushes and a saturating bubble counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned        INSTR_W  = 32,
    parameter int unsigned        PC_W     = 32,
    parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(NOP_WORD_DEF),
    parameter int unsigned        CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    pipe_stage_skid_if.slave bus,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic               m_valid, m_irq;
    logic [INSTR_W-1:0] m_instr;
    logic [PC_W-1:0]    m_pcplus;
    logic               s_valid, s_irq;
    logic [INSTR_W-1:0] s_instr;
    logic [PC_W-1:0]    s_pcplus;

    logic               in_ready_q;
    logic               irq_pending_q;

    logic               accept, advance, m_xfer, pend_eff;
    logic               m_load, m_clear, m_bubble;
    logic               s_load, s_clear;
    logic [INSTR_W-1:0] m_d_instr;
    logic [PC_W-1:0]    m_d_pcplus;
    logic               m_d_irq;
    logic               s_valid_next;
    logic               pend_next;

    always_comb begin
        accept   = bus.in_valid & in_ready_q;
        advance  = bus.out_ready | ~m_valid;
        m_xfer   = m_valid & bus.out_ready;
        // A pending irq already rides on main until main transfers; after that it is spent.
        pend_eff = irq_pending_q & ~m_xfer;

        m_d_instr  = s_valid ? s_instr  : bus.in_instr;
        m_d_pcplus = s_valid ? s_pcplus : bus.in_pcplus;
        m_d_irq    = (s_valid ? s_irq : bus.in_irq) | pend_eff;

        m_load       = 1'b0;
        m_clear      = 1'b0;
        m_bubble     = 1'b0;
        s_load       = 1'b0;
        s_clear      = 1'b0;
        s_valid_next = s_valid;
        pend_next    = pend_eff;

        if (flush) begin
            m_bubble     = 1'b1;
            s_clear      = 1'b1;
            s_valid_next = 1'b0;
            pend_next    = pend_eff
                         | (m_valid & m_irq & ~bus.out_ready)
                         | (s_valid & s_irq)
                         | bus.in_irq;
        end else if (advance) begin
            if (s_valid) begin
                m_load = 1'b1;
                if (accept) begin
                    s_load       = 1'b1;
                    s_valid_next = 1'b1;
                end else begin
                    s_clear      = 1'b1;
                    s_valid_next = 1'b0;
                end
            end else if (accept) begin
                m_load = 1'b1;
            end else begin
                m_clear = 1'b1;
            end
        end else if (accept) begin
            s_load       = 1'b1;
            s_valid_next = 1'b1;
        end
    end

    pipe_slot #(
        .INSTR_W  (INSTR_W),
        .PC_W     (PC_W),
        .NOP_WORD (NOP_WORD)
    ) u_main (
        .clk        (clk),
        .reset      (reset),
        .load       (m_load),
        .clear      (m_clear),
        .bubble     (m_bubble),
        .d_instr    (m_d_instr),
        .d_pcplus   (m_d_pcplus),
        .d_irq      (m_d_irq),
        .bub_pcplus (bus.in_pcplus),
        .q_instr    (m_instr),
        .q_pcplus   (m_pcplus),
        .q_irq      (m_irq),
        .q_valid    (m_valid)
    );

    pipe_slot #(
        .INSTR_W  (INSTR_W),
        .PC_W     (PC_W),
        .NOP_WORD (NOP_WORD)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (s_load),
        .clear      (s_clear),
        .bubble     (1'b0),
        .d_instr    (bus.in_instr),
        .d_pcplus   (bus.in_pcplus),
        .d_irq      (bus.in_irq),
        .bub_pcplus (s_pcplus),
        .q_instr    (s_instr),
        .q_pcplus   (s_pcplus),
        .q_irq      (s_irq),
        .q_valid    (s_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready_q    <= 1'b1;
            irq_pending_q <= 1'b0;
            bubble_cnt    <= '0;
        end else begin
            in_ready_q    <= ~s_valid_next;
            irq_pending_q <= pend_next;
            if (!m_valid)
                bubble_cnt <= CNT_W'(sat_inc(32'(bubble_cnt), CNT_W));
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = m_valid;
    assign bus.out_instr  = m_instr;
    assign bus.out_pcplus = m_pcplus;
    assign bus.out_irq    = m_irq;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: stimulus pushes expected beats, a monitor pops and compares.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [3:0] bubble_cnt;

    pipe_stage_skid_if #(.INSTR_W(32), .PC_W(32)) bus ();

    pipe_stage_skid #(
        .INSTR_W  (32),
        .PC_W     (32),
        .NOP_WORD (32'h0),
        .CNT_W    (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .bus        (bus),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    stage_entry_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] instr, input logic [31:0] pc, input logic irq);
        bus.in_valid  = 1'b1;
        bus.in_instr  = instr;
        bus.in_pcplus = pc;
        bus.in_irq    = irq;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_irq   = 1'b0;
    endtask

    task automatic expect_beat(input logic [31:0] instr, input logic [31:0] pc, input logic irq);
        stage_entry_t e;
        e.instr  = instr;
        e.pcplus = pc;
        e.irq    = irq;
        e.valid  = 1'b1;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every beat that transfers at the next edge is checked in order.
    always @(negedge clk) begin
        stage_entry_t e;
        if (reset && bus.out_valid && bus.out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL out_beat: got instr 0x%0h pcplus 0x%0h irq %0b, expected no beat",
                         bus.out_instr, bus.out_pcplus, bus.out_irq);
            end else begin
                e = exp_q.pop_front();
                if ({bus.out_instr, bus.out_pcplus, bus.out_irq} !== {e.instr, e.pcplus, e.irq}) begin
                    n_fail++;
                    $display("FAIL out_beat: got instr 0x%0h pcplus 0x%0h irq %0b, expected instr 0x%0h pcplus 0x%0h irq %0b",
                             bus.out_instr, bus.out_pcplus, bus.out_irq, e.instr, e.pcplus, e.irq);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by time 100000, expected finish earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pcplus = '0;
        bus.in_irq    = 1'b0;
        bus.out_ready = 1'b1;
        #1 reset = 1'b0;
        #2;

        // Reset state
        chk("rst_out_valid",  32'(bus.out_valid),  32'd0);
        chk("rst_out_instr",  bus.out_instr,       32'h0);
        chk("rst_out_pcplus", bus.out_pcplus,      32'h0);
        chk("rst_out_irq",    32'(bus.out_irq),    32'd0);
        chk("rst_in_ready",   32'(bus.in_ready),   32'd1);
        chk("rst_bubble_cnt", 32'(bubble_cnt),     32'd0);

        @(negedge clk);
        reset = 1'b1;
        tick(); chk("idle_bubble_1", 32'(bubble_cnt), 32'd1);
        tick(); chk("idle_bubble_2", 32'(bubble_cnt), 32'd2);
        tick(); chk("idle_bubble_3", 32'(bubble_cnt), 32'd3);

        // Back-to-back stream, one cycle latency, no gaps
        beat(32'h11, 32'h104, 1'b0); expect_beat(32'h11, 32'h104, 1'b0);
        tick(); chk("stream_v1", 32'(bus.out_valid), 32'd1); chk("stream_i1", bus.out_instr, 32'h11);
        beat(32'h22, 32'h108, 1'b0); expect_beat(32'h22, 32'h108, 1'b0);
        tick(); chk("stream_i2", bus.out_instr, 32'h22);
        beat(32'h33, 32'h10c, 1'b0); expect_beat(32'h33, 32'h10c, 1'b0);
        tick(); chk("stream_i3", bus.out_instr, 32'h33); chk("stream_rdy", 32'(bus.in_ready), 32'd1);
        idle();
        tick(); chk("stream_drain", 32'(bus.out_valid), 32'd0);

        // Three-cycle stall: skid absorbs 0x22, upstream holds 0x33
        beat(32'h11, 32'h204, 1'b0); expect_beat(32'h11, 32'h204, 1'b0);
        tick();
        bus.out_ready = 1'b0;
        beat(32'h22, 32'h208, 1'b0); expect_beat(32'h22, 32'h208, 1'b0);
        tick(); chk("stall_rdy_low", 32'(bus.in_ready), 32'd0); chk("stall_main", bus.out_instr, 32'h11);
        beat(32'h33, 32'h20c, 1'b0); expect_beat(32'h33, 32'h20c, 1'b0);
        tick(); chk("stall_rdy_hold", 32'(bus.in_ready), 32'd0);
        tick(); chk("stall_main_hold", bus.out_instr, 32'h11);
        bus.out_ready = 1'b1;
        tick(); chk("unstall_skid", bus.out_instr, 32'h22); chk("unstall_rdy", 32'(bus.in_ready), 32'd1);
        tick(); chk("unstall_next", bus.out_instr, 32'h33);
        idle();
        tick();

        // Flush with main=0x22, skid=0x33, stalled, dropped beat carrying irq
        beat(32'h22, 32'h304, 1'b0);
        tick();
        bus.out_ready = 1'b0;
        beat(32'h33, 32'h308, 1'b0);
        tick(); chk("pre_flush_rdy", 32'(bus.in_ready), 32'd0);
        flush = 1'b1;
        beat(32'h55, 32'h400, 1'b1);
        tick();
        flush = 1'b0;
        chk("flush_valid",  32'(bus.out_valid), 32'd0);
        chk("flush_instr",  bus.out_instr,      32'h0);
        chk("flush_pcplus", bus.out_pcplus,     32'h400);
        chk("flush_irq",    32'(bus.out_irq),   32'd0);
        chk("flush_rdy",    32'(bus.in_ready),  32'd1);
        bus.out_ready = 1'b1;
        beat(32'h44, 32'h504, 1'b0); expect_beat(32'h44, 32'h504, 1'b1);
        tick(); chk("irq_carried", 32'(bus.out_irq), 32'd1); chk("post_flush_instr", bus.out_instr, 32'h44);
        beat(32'h66, 32'h604, 1'b0); expect_beat(32'h66, 32'h604, 1'b0);
        tick(); chk("irq_cleared", 32'(bus.out_irq), 32'd0);
        idle();
        tick();

        // Reset asserted mid-stall with both entries full
        beat(32'h77, 32'h704, 1'b0);
        tick();
        bus.out_ready = 1'b0;
        beat(32'h88, 32'h708, 1'b0);
        tick();
        idle();
        chk("prerst_valid", 32'(bus.out_valid), 32'd1);
        chk("prerst_rdy",   32'(bus.in_ready),  32'd0);
        #2 reset = 1'b0;
        #1;
        chk("midrst_valid",  32'(bus.out_valid), 32'd0);
        chk("midrst_instr",  bus.out_instr,      32'h0);
        chk("midrst_pcplus", bus.out_pcplus,     32'h0);
        chk("midrst_irq",    32'(bus.out_irq),   32'd0);
        chk("midrst_rdy",    32'(bus.in_ready),  32'd1);
        chk("midrst_cnt",    32'(bubble_cnt),    32'd0);
        @(negedge clk);
        reset = 1'b1;
        bus.out_ready = 1'b1;

        // 2^4+5 bubble cycles: counter reaches 15 and stays there
        for (int i = 1; i <= 21; i++) begin
            tick();
            if (i == 14) chk("sat_cnt_14", 32'(bubble_cnt), 32'd14);
            if (i == 15) chk("sat_cnt_15", 32'(bubble_cnt), 32'd15);
            if (i == 16) chk("sat_no_wrap", 32'(bubble_cnt), 32'd15);
        end
        chk("sat_final", 32'(bubble_cnt), 32'd15);

        tick();
        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register for the five-stage MIPS core, replacing the fixed 32-bit IF/ID latch. It carries instruction, PC+4 and an interrupt flag through a two-entry (main + skid) buffer with a valid/ready handshake, so a stall never loses a beat. A flush inserts a NOP bubble and keeps the PC+4 for exception return. Interrupts that arrive on a flushed beat stay pending and are not lost. One instance sits between IF and ID; the same block is reused between later stages.

## Interface
- INSTR_W, 32, instruction payload width
- PC_W, 32, PC+4 payload width
- NOP_WORD, 32'h0, instruction value driven for bubbles
- CNT_W, 16, bubble counter width
- clk  in  1  rising-edge clock (the single clock; no other clock domain)
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat (registered)
- in_instr  in  INSTR_W  fetched instruction
- in_pcplus  in  PC_W  PC+4 of fetched instruction
- in_irq  in  1  interrupt request tagged to this beat
- flush  in  1  branch/jump/exception redirect (nonzero PCSrc)
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts (low = data hazard stall)
- out_instr  out  INSTR_W  instruction to decode, NOP_WORD when not valid
- out_pcplus  out  PC_W  PC+4 of output entry
- out_irq  out  1  interrupt attached to output beat
- bubble_cnt  out  CNT_W  saturating count of cycles with out_valid=0

## Operation
- Entries: main (drives outputs) and skid. Each holds {instr, pcplus, irq, valid}.
- accept = in_valid & in_ready. advance = out_ready | ~out_valid.
- When advance is true, main loads the skid entry if the skid is valid. Otherwise main loads the accepted beat. If nothing is available, main goes invalid and out_instr is NOP_WORD.
- When advance is false and a beat is accepted, the beat goes into the skid. in_ready is 0 the next cycle.
- in_ready is registered as ~skid_valid_next. Order is strictly FIFO.
- Flush has priority over all other events:
  - main becomes a bubble: valid=0, instr=NOP_WORD, pcplus=in_pcplus.
  - The skid is cleared.
  - The beat presented on the flush cycle is consumed and discarded.
  - in_ready is 1 the cycle after the flush.
- irq_pending is sticky. It is set when a flushed or discarded entry carried irq=1, or when in_irq is high during a flush.
- irq_pending is ORed into the irq of the next valid beat loaded into main. It clears when that beat transfers (out_valid & out_ready).
- bubble_cnt increments every cycle that out_valid=0 and saturates at all-ones. It does not wrap.

## Timing
- Reset values: out_valid=0, out_instr=NOP_WORD, out_pcplus=0, out_irq=0, in_ready=1, bubble_cnt=0, irq_pending=0, skid empty.
- Reset takes effect mid-operation at any cycle and drops all entries.
- Latency is 1 cycle: a beat accepted at edge N appears on the outputs after edge N when the stage was empty or advancing.
- Throughput is 1 beat/cycle while out_ready=1.
- A stall absorbs at most one extra beat. in_ready falls one cycle after the skid fills.
- If out_ready rises while the skid is full, the skid moves to main and in_ready returns to 1 at the next edge.
- Flush together with stall: the flush wins, and out_valid=0 after the edge regardless of out_ready.
- Flush together with accept: the beat is dropped and its irq goes into irq_pending.
- Outputs are register-driven. No combinational path runs from inputs to outputs except none (in_ready is also registered).

## Structure
- Shared package pipe_pkg holds:
  - stage_entry_t typedef {instr, pcplus, irq, valid}, parametrised by width localparams
  - NOP_WORD default
  - the bubble counter saturation helper
- Sub-module pipe_slot: a single entry register with load/clear/bubble controls, instantiated twice (main, skid).
- The top level holds the handshake logic, irq_pending and bubble_cnt.

## Test plan
- Reset release, no input: out_valid=0, out_instr=0, in_ready=1, bubble_cnt counts 1,2,3…
- Stream beats 0x11,0x22,0x33 with out_ready=1: outputs appear one cycle later in order, with no gaps.
- Stall out_ready=0 for 3 cycles during the stream: the skid holds 0x22, in_ready=0, and after release the output is 0x11,0x22,0x33 with nothing lost or duplicated.
- Flush while main=0x22 and skid=0x33 with in_pcplus=0x400: next cycle out_valid=0, out_instr=NOP, out_pcplus=0x400, skid empty; the next beat 0x44 passes normally.
- in_irq=1 on a beat dropped by flush: out_irq=1 on the next valid beat 0x44, then clears after it transfers.
- Hold out_valid=0 for 2^CNT_W+5 cycles with CNT_W=4: bubble_cnt stops at 15. Assert reset mid-stall: all outputs return to reset values immediately.
